ysyx_22041461_shift_seq: RTL and testbench

Multi-cycle RV64 shift sequencer for the EXU. It accepts one shift operation (SLL/SRL/SRA and the 32-bit W variants) over a valid/ready handshake and iterates a narrow STEP-bit shift stage until the full shift amount is consumed. It returns the sign-correct 64-bit result over a second valid/ready handshake. It sits between the EXU issue logic and the writeback mux, and replaces the single-cycle 64-bit barrel shifter on area-constrained builds.

---
 rtl/ysyx_22041461_shift_defs.sv | 26 ++
 rtl/ysyx_22041461_shift_step.sv | 25 ++
 rtl/ysyx_22041461_shift_seq.sv | 119 +++++++++++
 tb/tb_ysyx_22041461_shift_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041461_shift_defs.sv
// Shared encodings for the EXU shift path: op codes and sequencer FSM states.
// The EXU decode uses the same op constants when it issues to the shift sequencer.
// Encodings 6 and 7 are reserved ops and produce a zero result.
package ysyx_22041461_shift_defs;

  typedef enum logic [2:0] {
    SHOP_SLL  = 3'd0,
    SHOP_SRL  = 3'd1,
    SHOP_SRA  = 3'd2,
    SHOP_SLLW = 3'd3,
    SHOP_SRLW = 3'd4,
    SHOP_SRAW = 3'd5
  } shop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } shst_e;

  // True for the 32-bit W variants, whose results are sign-extended from bit 31.
  function automatic logic f_is_wop(input logic [2:0] op);
    return (op == SHOP_SLLW) || (op == SHOP_SRLW) || (op == SHOP_SRAW);
  endfunction

endpackage

// File: rtl/ysyx_22041461_shift_step.sv
// Narrow shift stage: shifts a 64-bit word by at most STEP bits.
// Combinational, zero latency.
// No handshake; the sequencer supplies a new word every cycle.
module ysyx_22041461_shift_step #(
  parameter int STEP = 8,
  parameter int NW   = $clog2(STEP) + 1
) (
  input  logic [63:0]   i_work,
  input  logic [NW-1:0] i_n,
  input  logic          i_left,
  input  logic          i_arith,
  output logic [63:0]   o_word
);

  // Select the shift direction; arith right replicates bit 63.
  always_comb begin
    if (i_left)
      o_word = i_work << i_n;
    else if (i_arith)
      o_word = $unsigned($signed(i_work) >>> i_n);
    else
      o_word = i_work >> i_n;
  end

endmodule

// File: rtl/ysyx_22041461_shift_seq.sv
// Multi-cycle RV64 shifter: iterates a STEP-bit stage until the shift amount is consumed.
// Latency: ceil(shamt/STEP)+1 cycles from accept to out_valid (1 cycle for zero shift).
// Backpressure: the result is held stable in DONE until out_ready; no new accept until then.
import ysyx_22041461_shift_defs::*;

module ysyx_22041461_shift_seq #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [63:0] in_src1,
  input  logic [5:0]  in_shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        busy
);

  localparam int NW = $clog2(STEP) + 1;

  shst_e       r_state;
  logic [2:0]  r_op;
  logic [5:0]  r_rem;
  logic [63:0] r_work;

  logic          w_in_w;
  logic          w_in_rsv;
  logic [5:0]    w_eff_shamt;
  logic [63:0]   w_load;
  logic          w_left;
  logic          w_arith;
  logic [5:0]    w_n6;
  logic [NW-1:0] w_n;
  logic [63:0]   w_step;

  // Request-side decode: effective shift amount and the initial work word.
  always_comb begin
    w_in_w   = f_is_wop(in_op);
    w_in_rsv = (in_op > SHOP_SRAW);
    if (w_in_rsv)
      w_eff_shamt = 6'd0;
    else if (w_in_w)
      w_eff_shamt = {1'b0, in_shamt[4:0]};
    else
      w_eff_shamt = in_shamt;
    case (in_op)
      SHOP_SLL, SHOP_SRL, SHOP_SRA, SHOP_SLLW: w_load = in_src1;
      SHOP_SRLW: w_load = {32'b0, in_src1[31:0]};
      SHOP_SRAW: w_load = {{32{in_src1[31]}}, in_src1[31:0]};
      default:   w_load = 64'd0;
    endcase
  end

  // Per-step control from the latched op: direction, arith flag, n = min(rem, STEP).
  always_comb begin
    w_left  = (r_op == SHOP_SLL) || (r_op == SHOP_SLLW);
    w_arith = (r_op == SHOP_SRA) || (r_op == SHOP_SRAW);
    w_n6    = (r_rem > 6'(STEP)) ? 6'(STEP) : r_rem;
    w_n     = w_n6[NW-1:0];
  end

  ysyx_22041461_shift_step #(
    .STEP (STEP),
    .NW   (NW)
  ) u_step (
    .i_work  (r_work),
    .i_n     (w_n),
    .i_left  (w_left),
    .i_arith (w_arith),
    .o_word  (w_step)
  );

  // Sequencer FSM: accept, step until rem is exhausted, hold result until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= 3'd0;
      r_rem   <= 6'd0;
      r_work  <= 64'd0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op    <= in_op;
            r_rem   <= w_eff_shamt;
            r_work  <= w_load;
            r_state <= (w_eff_shamt == 6'd0) ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_work <= w_step;
          r_rem  <= r_rem - w_n6;
          if (r_rem == w_n6)
            r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake flags come from registered state only; W results sign-extend bit 31.
  always_comb begin
    in_ready   = (r_state == ST_IDLE);
    out_valid  = (r_state == ST_DONE);
    busy       = (r_state == ST_BUSY) || (r_state == ST_DONE);
    out_result = f_is_wop(r_op) ? {{32{r_work[31]}}, r_work[31:0]} : r_work;
  end

endmodule

// File: tb/tb_ysyx_22041461_shift_seq.sv
// Bench for the shift sequencer: behavioural result/latency model plus directed vectors.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A transaction-level model is checked every cycle alongside literal expectations.
module tb_ysyx_22041461_shift_seq;

  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [63:0] in_src1 = 64'd0;
  logic [5:0]  in_shamt = 6'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        busy;

  int total = 0;
  int bad = 0;

  ysyx_22041461_shift_seq #(.STEP(STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Architectural result of an RV64 shift, straight from the ISA definition.
  function automatic logic [63:0] f_model(input logic [2:0] op, input logic [63:0] s,
                                          input logic [5:0] sh);
    logic [31:0] lo;
    logic [4:0]  s5;
    s5 = sh[4:0];
    case (op)
      3'd0: return s << sh;
      3'd1: return s >> sh;
      3'd2: return $unsigned($signed(s) >>> sh);
      3'd3: begin lo = s[31:0] << s5; return {{32{lo[31]}}, lo}; end
      3'd4: begin lo = s[31:0] >> s5; return {{32{lo[31]}}, lo}; end
      3'd5: begin lo = $unsigned($signed(s[31:0]) >>> s5); return {{32{lo[31]}}, lo}; end
      default: return 64'd0;
    endcase
  endfunction

  // Number of step cycles: ceil(effective shamt / STEP).
  function automatic int f_steps(input logic [2:0] op, input logic [5:0] sh);
    int eff;
    if (op > 3'd5) eff = 0;
    else if (op >= 3'd3) eff = int'(sh[4:0]);
    else eff = int'(sh);
    return (eff + STEP - 1) / STEP;
  endfunction

  // Transaction model: pending work countdown, then a result waiting for the consumer.
  bit          m_pending = 1'b0;
  bit          m_valid = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_res = 64'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending = 1'b0;
      m_valid   = 1'b0;
      m_cnt     = 0;
      m_res     = 64'd0;
    end else if (flush) begin
      m_pending = 1'b0;
      m_valid   = 1'b0;
    end else if (!m_pending && !m_valid) begin
      if (in_valid) begin
        m_res = f_model(in_op, in_src1, in_shamt);
        m_cnt = f_steps(in_op, in_shamt);
        if (m_cnt == 0) m_valid = 1'b1;
        else m_pending = 1'b1;
      end
    end else if (m_pending) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_pending = 1'b0;
        m_valid   = 1'b1;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    check("mdl_in_ready", 64'(in_ready), 64'(!m_pending && !m_valid));
    check("mdl_out_valid", 64'(out_valid), 64'(m_valid));
    check("mdl_busy", 64'(busy), 64'(m_pending || m_valid));
    if (rst) check("mdl_rst_result", out_result, 64'd0);
    else if (m_valid) check("mdl_result", out_result, m_res);
  end

  // Issue one op, measure cycles from accept to out_valid, check result and hold, then consume.
  task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] s,
                        input logic [5:0] sh, input logic [63:0] exp_res, input int exp_lat,
                        input int hold);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_src1 = s; in_shamt = sh;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_res"}, out_result, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_res"}, out_result, exp_res);
      check({name, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, "_back_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", out_result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("sll63", 3'd0, 64'h1, 6'd63, 64'h8000_0000_0000_0000, 9, 0);
    run_op("sraw35", 3'd5, 64'h0000_0000_8000_0000, 6'd35, 64'hFFFF_FFFF_F000_0000, 2, 0);
    run_op("srlw4", 3'd4, 64'hFFFF_FFFF_8000_0000, 6'd4, 64'h0000_0000_0800_0000, 2, 0);
    run_op("sra0", 3'd2, 64'h8000_0000_0000_0000, 6'd0, 64'h8000_0000_0000_0000, 1, 5);
    run_op("sllw31", 3'd3, 64'h1, 6'd31, 64'hFFFF_FFFF_8000_0000, 5, 0);
    run_op("sra63", 3'd2, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 9, 0);
    run_op("srl17", 3'd1, 64'hFFFF_0000_0000_0000, 6'd17, 64'h0000_7FFF_8000_0000, 4, 2);

    // Flush in idle with a request present: the request must not be taken.
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_src1 = 64'h3; in_shamt = 6'd5;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_rdy", 64'(in_ready), 64'd1);
    check("flush_idle_busy", 64'(busy), 64'd0);

    // Flush during the third BUSY cycle of SLL by 40.
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd0; in_src1 = 64'h1; in_shamt = 6'd40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy_rdy", 64'(in_ready), 64'd1);
    check("flush_busy_ov", 64'(out_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("flush_no_ov", 64'(out_valid), 64'd0);
    end
    run_op("srl_f0", 3'd1, 64'hF0, 6'd4, 64'hF, 2, 0);

    // Asynchronous reset in the middle of a BUSY phase.
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd0; in_src1 = 64'h5; in_shamt = 6'd63;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_result", out_result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("arst_no_ov", 64'(out_valid), 64'd0);
    end

    run_op("rsv7", 3'd7, 64'hDEAD_BEEF_1234_5678, 6'd12, 64'd0, 1, 0);
    run_op("rsv6", 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'd0, 1, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
